hazard_unit: RTL and testbench
==============================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
- REQ-001 SHALL provide parameter REG_AW, default 5, register-index width.
- REQ-002 SHALL provide parameter CNT_W, default 32, performance-counter width; used only when HAZARD_PERF_CNT_EN is defined.
- REQ-003 SHALL have a single clock and an asynchronous, active-low reset; reset is the only asynchronous path.
- REQ-004 clk  input  1  rising-edge clock.
- REQ-005 rst_n  input  1  asynchronous active-low reset.
- REQ-006 Rs1E, Rs2E  input  REG_AW  source registers of the instruction in Execute.
- REQ-007 RdE  input  REG_AW  destination register in Execute.
- REQ-008 Rs1D, Rs2D  input  REG_AW  source registers of the instruction in Decode.
- REQ-009 RdM, RdW  input  REG_AW  destination registers in Memory and Writeback.
- REQ-010 RegWriteM, RegWriteW  input  1  register-write enables for Memory and Writeback.
- REQ-011 ResultSrcE  input  2  result select in Execute; bit 0 = 1 marks a load.
- REQ-012 PCSrcE  input  1  branch or jump taken in Execute.
- REQ-013 ForwardAE, ForwardBE  output  2  ALU operand A/B forward select.
- REQ-014 StallF, StallD  output  1  hold the Fetch and Decode pipeline registers.
- REQ-015 FlushD, FlushE  output  1  clear the Decode and Execute pipeline registers.
- REQ-016 perf_clr  input  1  synchronous counter clear; present only with HAZARD_PERF_CNT_EN.
- REQ-017 stall_cnt, flush_cnt  output  CNT_W  event counters; present only with HAZARD_PERF_CNT_EN.

Function
- REQ-018 ForwardAE SHALL be 2'b10 when Rs1E==RdM, RegWriteM=1 and Rs1E!=0.
- REQ-019 Otherwise, ForwardAE SHALL be 2'b01 when Rs1E==RdW, RegWriteW=1 and Rs1E!=0; otherwise 2'b00.
- REQ-020 The Memory-stage match SHALL take priority over the Writeback-stage match.
- REQ-021 ForwardBE SHALL follow the same rules as ForwardAE, using Rs2E.
- REQ-022 lwStall SHALL equal ResultSrcE[0] AND RdE!=0 AND (Rs1D==RdE OR Rs2D==RdE).
- REQ-023 StallF and StallD SHALL both equal lwStall.
- REQ-024 FlushD SHALL equal PCSrcE.
- REQ-025 FlushE SHALL equal lwStall OR PCSrcE; when both are true it is a single assertion.
- REQ-026 All hazard outputs SHALL be purely combinational, have zero latency, and be independent of clk and rst_n.

Reset
- REQ-027 The combinational hazard outputs SHALL NOT be affected by rst_n.
- REQ-028 When present, stall_cnt and flush_cnt SHALL reset asynchronously to 0 on rst_n low and resume counting on the first rising edge after release.

Configuration
- REQ-029 With macro HAZARD_PERF_CNT_EN defined, the counters SHALL be built as follows:
  - stall_cnt increments on each clk edge where lwStall=1.
  - flush_cnt increments on each clk edge where PCSrcE=1.
  - Both saturate at all-ones and do not wrap.
  - perf_clr=1 forces both to 0 on the next edge; clear wins over a simultaneous event.
- REQ-030 Without HAZARD_PERF_CNT_EN, perf_clr, stall_cnt, flush_cnt and all sequential logic SHALL be absent; clk and rst_n remain as unused ports.

Structure
- REQ-031 Shared package hazard_pkg SHALL hold:
  - FWD_NONE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - RES_LOAD_BIT=0.
  - The REG_AW default.
- REQ-032 The design SHALL contain one sub-module, hazard_perf_cnt (saturating counter with clear), instantiated twice under the macro.

Verification
- REQ-033 Idle, no forwarding or stall:
  - Stimulus: Rs1E=1, Rs2E=2, RdE=0, Rs1D=3, Rs2D=4, RdM=RdW=0, all write enables 0, ResultSrcE=00, PCSrcE=0.
  - Response: all outputs 0.
- REQ-034 Forward from Memory, then Writeback:
  - Rs1E=5, RdM=5, RegWriteM=1 -> ForwardAE=10.
  - Then Rs2E=6, RdW=6, RegWriteW=1 -> ForwardBE=01 and ForwardAE stays 10.
- REQ-035 Priority and x0 handling:
  - Rs1E=RdM=RdW=9 with both write enables 1 -> ForwardAE=10.
  - Rs1E=RdM=0 with RegWriteM=1 -> ForwardAE=00.
- REQ-036 Load-use stall:
  - Rs1D=7, RdE=7, ResultSrcE=01 -> StallF=StallD=FlushE=1, FlushD=0.
  - Same registers with ResultSrcE=00 -> all four outputs 0.
- REQ-037 Taken branch:
  - PCSrcE=1 -> FlushD=FlushE=1.
  - Combined with Rs2D=RdE=8 and ResultSrcE=01 -> additionally StallF=StallD=1.
- REQ-038 Counters, with HAZARD_PERF_CNT_EN defined:
  - 3 cycles of lwStall -> stall_cnt=3.
  - perf_clr together with PCSrcE=1 -> flush_cnt=0 on the next edge.
  - rst_n low mid-count -> both counters 0 immediately.

Source files
------------

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared constants for the pipeline hazard unit
package hazard_pkg;

    localparam int REG_AW_DEF = 5;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    // Bit of ResultSrcE that marks a load in Execute
    localparam int RES_LOAD_BIT = 0;

endpackage

// File: rtl/hazard_perf_cnt.sv
// rtl/hazard_perf_cnt.sv - saturating event counter with synchronous clear
module hazard_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - forwarding, load-use stall and flush control
// Optional stall/flush event counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef HAZARD_PERF_CNT_EN
    input  logic              perf_clr,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
`endif
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic [1:0]        ResultSrcE,
    input  logic              PCSrcE,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushD,
    output logic              FlushE
);

    logic rs1MemHit;
    logic rs1WbHit;
    logic rs2MemHit;
    logic rs2WbHit;
    logic lwStall;

    // x0 is hardwired to zero, so it is never a forwarding source
    assign rs1MemHit = RegWriteM && (Rs1E == RdM) && (Rs1E != '0);
    assign rs1WbHit  = RegWriteW && (Rs1E == RdW) && (Rs1E != '0);
    assign rs2MemHit = RegWriteM && (Rs2E == RdM) && (Rs2E != '0);
    assign rs2WbHit  = RegWriteW && (Rs2E == RdW) && (Rs2E != '0);

    always_comb begin
        ForwardAE = FWD_NONE;
        if (rs1MemHit) begin
            ForwardAE = FWD_MEM;
        end else if (rs1WbHit) begin
            ForwardAE = FWD_WB;
        end
    end

    always_comb begin
        ForwardBE = FWD_NONE;
        if (rs2MemHit) begin
            ForwardBE = FWD_MEM;
        end else if (rs2WbHit) begin
            ForwardBE = FWD_WB;
        end
    end

    assign lwStall = ResultSrcE[RES_LOAD_BIT] && (RdE != '0) &&
                     ((Rs1D == RdE) || (Rs2D == RdE));

    assign StallF = lwStall;
    assign StallD = lwStall;
    assign FlushD = PCSrcE;
    assign FlushE = lwStall || PCSrcE;

`ifdef HAZARD_PERF_CNT_EN
    hazard_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (perf_clr),
        .inc   (lwStall),
        .cnt   (stall_cnt)
    );

    hazard_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (perf_clr),
        .inc   (PCSrcE),
        .cnt   (flush_cnt)
    );
`else
    // Clock, reset and counter width only matter when the counters are built
    localparam int unusedCntW = CNT_W;
    logic unusedPorts;
    assign unusedPorts = clk ^ rst_n;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - self-checking bench for hazard_unit
module tb_hazard_unit;

    localparam int AW  = 5;
    localparam int CW  = 4;
    localparam int MAXC = (1 << CW) - 1;

    typedef struct {
        logic [AW-1:0] rs1E, rs2E, rdE, rs1D, rs2D, rdM, rdW;
        logic          wM, wW;
        logic [1:0]    rsrc;
        logic          pc;
        logic [1:0]    eFA, eFB;
        logic          eStall, eFD, eFE;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [AW-1:0] Rs1E, Rs2E, RdE, Rs1D, Rs2D, RdM, RdW;
    logic RegWriteM, RegWriteW, PCSrcE;
    logic [1:0] ResultSrcE;
    logic [1:0] ForwardAE, ForwardBE;
    logic StallF, StallD, FlushD, FlushE;
    logic perf_clr = 1'b0;
`ifdef HAZARD_PERF_CNT_EN
    logic [CW-1:0] stall_cnt, flush_cnt;
`endif

    int checks = 0;
    int errors = 0;
    vec_t cur;
    vec_t tbl[12];
    int mStall = 0;
    int mFlush = 0;

    always #5 clk = ~clk;

    hazard_unit #(.REG_AW(AW), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef HAZARD_PERF_CNT_EN
        .perf_clr   (perf_clr),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt),
`endif
        .Rs1E       (Rs1E),
        .Rs2E       (Rs2E),
        .RdE        (RdE),
        .Rs1D       (Rs1D),
        .Rs2D       (Rs2D),
        .RdM        (RdM),
        .RdW        (RdW),
        .RegWriteM  (RegWriteM),
        .RegWriteW  (RegWriteW),
        .ResultSrcE (ResultSrcE),
        .PCSrcE     (PCSrcE),
        .ForwardAE  (ForwardAE),
        .ForwardBE  (ForwardBE),
        .StallF     (StallF),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .FlushE     (FlushE)
    );

    function automatic vec_t mk(input int rs1E, rs2E, rdE, rs1D, rs2D, rdM, rdW,
                                input int wM, wW, rsrc, pc, eFA, eFB, eSt, eFD, eFE);
        vec_t v;
        v.rs1E = AW'(rs1E); v.rs2E = AW'(rs2E); v.rdE = AW'(rdE);
        v.rs1D = AW'(rs1D); v.rs2D = AW'(rs2D); v.rdM = AW'(rdM); v.rdW = AW'(rdW);
        v.wM = 1'(wM); v.wW = 1'(wW); v.rsrc = 2'(rsrc); v.pc = 1'(pc);
        v.eFA = 2'(eFA); v.eFB = 2'(eFB); v.eStall = 1'(eSt); v.eFD = 1'(eFD); v.eFE = 1'(eFE);
        return v;
    endfunction

    // Youngest producing stage wins; register 0 never forwards
    function automatic logic [1:0] refFwd(input logic [AW-1:0] rs, input vec_t v);
        logic [AW-1:0] dst[2];
        logic          wen[2];
        logic [1:0]    code[2];
        dst = '{v.rdM, v.rdW};
        wen = '{v.wM, v.wW};
        code = '{2'd2, 2'd1};
        if (rs == 0) return 2'd0;
        for (int s = 0; s < 2; s++)
            if (wen[s] && dst[s] == rs) return code[s];
        return 2'd0;
    endfunction

    function automatic vec_t refExpect(input vec_t v);
        vec_t r = v;
        bit isLoad = v.rsrc[0];
        bit uses   = (v.rs1D == v.rdE) || (v.rs2D == v.rdE);
        r.eFA = refFwd(v.rs1E, v);
        r.eFB = refFwd(v.rs2E, v);
        r.eStall = isLoad && v.rdE != 0 && uses;
        r.eFD = v.pc;
        r.eFE = r.eStall || v.pc;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        cur = v;
        Rs1E = v.rs1E; Rs2E = v.rs2E; RdE = v.rdE; Rs1D = v.rs1D; Rs2D = v.rs2D;
        RdM = v.rdM; RdW = v.rdW; RegWriteM = v.wM; RegWriteW = v.wW;
        ResultSrcE = v.rsrc; PCSrcE = v.pc;
    endtask

    task automatic checkOut(input string tag, input vec_t v);
        chk({tag, ".ForwardAE"}, 32'(ForwardAE), 32'(v.eFA));
        chk({tag, ".ForwardBE"}, 32'(ForwardBE), 32'(v.eFB));
        chk({tag, ".StallF"}, 32'(StallF), 32'(v.eStall));
        chk({tag, ".StallD"}, 32'(StallD), 32'(v.eStall));
        chk({tag, ".FlushD"}, 32'(FlushD), 32'(v.eFD));
        chk({tag, ".FlushE"}, 32'(FlushE), 32'(v.eFE));
    endtask

`ifdef HAZARD_PERF_CNT_EN
    always @(posedge clk or negedge rst_n) begin
        vec_t e;
        if (!rst_n) begin
            mStall = 0;
            mFlush = 0;
        end else if (perf_clr) begin
            mStall = 0;
            mFlush = 0;
        end else begin
            e = refExpect(cur);
            if (e.eStall && mStall < MAXC) mStall = mStall + 1;
            if (cur.pc && mFlush < MAXC) mFlush = mFlush + 1;
        end
    end

    task automatic chkCnt(input string tag, input int expS, input int expF);
        chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(expS));
        chk({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(expF));
    endtask
`endif

    initial begin
        vec_t idle, ld, br, r;
        idle = mk(1, 2, 0, 3, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        ld   = mk(1, 2, 7, 7, 4, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1);
        br   = mk(1, 2, 8, 3, 8, 0, 0, 0, 0, 1, 1, 0, 0, 1, 1, 1);

        tbl[0]  = idle;
        tbl[1]  = mk(5, 2, 0, 3, 4, 5, 0, 1, 0, 0, 0, 2, 0, 0, 0, 0);
        tbl[2]  = mk(5, 6, 0, 3, 4, 5, 6, 1, 1, 0, 0, 2, 1, 0, 0, 0);
        tbl[3]  = mk(9, 2, 0, 3, 4, 9, 9, 1, 1, 0, 0, 2, 0, 0, 0, 0);
        tbl[4]  = mk(0, 2, 0, 3, 4, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[5]  = ld;
        tbl[6]  = mk(1, 2, 7, 7, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[7]  = mk(1, 2, 0, 3, 4, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1);
        tbl[8]  = br;
        tbl[9]  = mk(1, 2, 0, 0, 4, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0);
        tbl[10] = mk(1, 2, 7, 7, 4, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0);
        tbl[11] = mk(31, 6, 0, 3, 4, 31, 6, 1, 1, 0, 0, 2, 1, 0, 0, 0);

        // Hazard outputs must respond while reset is held
        apply(br);
        #2;
        checkOut("in_reset", br);
`ifdef HAZARD_PERF_CNT_EN
        chkCnt("in_reset", 0, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            apply(tbl[i]);
            #1;
            checkOut($sformatf("vec%0d", i), tbl[i]);
        end

`ifdef HAZARD_PERF_CNT_EN
        @(negedge clk);
        apply(idle);
        perf_clr = 1'b1;
        @(negedge clk);
        perf_clr = 1'b0;
        chkCnt("cleared", 0, 0);
        apply(ld);
        repeat (3) @(negedge clk);
        apply(idle);
        chk("three_stalls.stall_cnt", 32'(stall_cnt), 32'd3);

        apply(br);
        perf_clr = 1'b1;
        @(negedge clk);
        perf_clr = 1'b0;
        apply(tbl[7]);
        chkCnt("clr_wins", 0, 0);

        repeat (2) @(negedge clk);
        chk("two_flush.flush_cnt", 32'(flush_cnt), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chkCnt("async_reset", 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        apply(br);
        repeat (20) @(negedge clk);
        chkCnt("saturate", MAXC, MAXC);
        perf_clr = 1'b1;
        @(negedge clk);
        perf_clr = 1'b0;
`endif

        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
`ifdef HAZARD_PERF_CNT_EN
            chkCnt($sformatf("rnd%0d", i), mStall, mFlush);
            perf_clr = ($urandom_range(0, 15) == 0);
`endif
            r = mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
                   $urandom_range(0, 3), ($urandom_range(0, 3) == 0) ? 1 : 0,
                   0, 0, 0, 0, 0);
            r = refExpect(r);
            apply(r);
            #1;
            checkOut($sformatf("rnd%0d", i), r);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
